// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - centisecond BCD stopwatch engine (MM:SS.cc) with start/stop, lap and clear
//
// Purpose: synchronises and edge-detects three push buttons, runs a prescaled
// six-digit BCD counter and drives the digit codes for the 7-segment decoders.
// Digit code 10 selects the decoder dash pattern and marks overflow.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   btn_start/lap/clear raw active-high buttons, asynchronous to clk
//   dig_cs0/cs1         centiseconds units/tens
//   dig_s0/s1           seconds units/tens
//   dig_m0/m1           minutes units/tens
//   running             high while counting (RUN or LAP)
//   ovf                 high once 59:59.99 has been exceeded
module stopwatch_core #(
   parameter int TICK_DIV = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic [3:0] dig_cs0,
   output logic [3:0] dig_cs1,
   output logic [3:0] dig_s0,
   output logic [3:0] dig_s1,
   output logic [3:0] dig_m0,
   output logic [3:0] dig_m1,
   output logic       running,
   output logic       ovf
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PS_TOP = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {IDLE, RUN, PAUSED, LAP, OVF} state_t;
   state_t state, state_nxt;

   // Bit 0 = start, 1 = lap, 2 = clear
   logic [2:0] sync1, sync2, sync3, press;
   logic       press_start, press_lap, press_clear;

   logic [PW-1:0] presc;
   logic [3:0]    cs0, cs1, s0, s1, m0, m1;
   logic [3:0]    n_cs0, n_cs1, n_s0, n_s1, n_m0, n_m1;
   logic [23:0]   cnt_vec, snap, disp;
   logic          counting, tick, at_max, clear_all;

   // Two-flop synchroniser, then a registered rising-edge pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
         press <= '0;
      end else begin
         sync1 <= {btn_clear, btn_lap, btn_start};
         sync2 <= sync1;
         sync3 <= sync2;
         press <= sync2 & ~sync3;
      end
   end

   // Clear outranks start, start outranks lap; lower presses are discarded
   assign press_clear = press[2];
   assign press_start = press[0] & ~press[2];
   assign press_lap   = press[1] & ~press[0] & ~press[2];

   assign counting  = (state == RUN) || (state == LAP);
   assign tick      = counting && (presc == PS_TOP);
   assign cnt_vec   = {m1, m0, s1, s0, cs1, cs0};
   assign at_max    = (cnt_vec == 24'h595999);
   assign clear_all = press_clear && ((state == PAUSED) || (state == OVF));

   // Single-clock BCD carry ripple
   always_comb begin
      n_cs0 = cs0;
      n_cs1 = cs1;
      n_s0  = s0;
      n_s1  = s1;
      n_m0  = m0;
      n_m1  = m1;
      if (cs0 != 4'd9) n_cs0 = cs0 + 4'd1;
      else begin
         n_cs0 = 4'd0;
         if (cs1 != 4'd9) n_cs1 = cs1 + 4'd1;
         else begin
            n_cs1 = 4'd0;
            if (s0 != 4'd9) n_s0 = s0 + 4'd1;
            else begin
               n_s0 = 4'd0;
               if (s1 != 4'd5) n_s1 = s1 + 4'd1;
               else begin
                  n_s1 = 4'd0;
                  if (m0 != 4'd9) n_m0 = m0 + 4'd1;
                  else begin
                     n_m0 = 4'd0;
                     n_m1 = (m1 != 4'd5) ? m1 + 4'd1 : 4'd0;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear_all) begin
         presc <= '0;
         {m1, m0, s1, s0, cs1, cs0} <= '0;
         snap  <= '0;
      end else begin
         // Prescaler holds outside RUN/LAP so a resume keeps the fraction
         if (counting) presc <= tick ? '0 : presc + PW'(1);
         // The overflowing tick leaves the counter frozen at 59:59.99
         if (tick && !at_max) {m1, m0, s1, s0, cs1, cs0} <= {n_m1, n_m0, n_s1, n_s0, n_cs1, n_cs0};
         // Snapshot takes the pre-increment value if a tick lands on this edge
         if ((state == RUN) && press_lap) snap <= cnt_vec;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (press_start) state_nxt = RUN;
         RUN: begin
            if (tick && at_max)   state_nxt = OVF;
            else if (press_start) state_nxt = PAUSED;
            else if (press_lap)   state_nxt = LAP;
         end
         LAP: begin
            if (tick && at_max)   state_nxt = OVF;
            else if (press_start) state_nxt = PAUSED;
            else if (press_lap)   state_nxt = RUN;
         end
         PAUSED: begin
            if (press_clear)      state_nxt = IDLE;
            else if (press_start) state_nxt = RUN;
         end
         OVF:     if (press_clear) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      disp    = cnt_vec;
      running = 1'b0;
      ovf     = 1'b0;
      unique case (state)
         RUN:     running = 1'b1;
         LAP: begin
            running = 1'b1;
            disp    = snap;
         end
         OVF: begin
            ovf  = 1'b1;
            disp = {6{4'd10}};
         end
         default: ;
      endcase
   end

   assign {dig_m1, dig_m0, dig_s1, dig_s0, dig_cs1, dig_cs0} = disp;

endmodule
